// File: rtl/network_feeder_if.sv
// Bundles the word stream, the input-frame bus and the teacher-frame bus of network_feeder.
// The master modport is the feeder's view; the slave modport is the host/network side.
interface network_feeder_if #(
  parameter int NI  = 4,
  parameter int NH1 = 6,
  parameter int NO  = 7,
  parameter int WF  = 8
);
  localparam int WT = $clog2(NH1) + 1 + WF;

  logic                iMode;
  logic                iValid_AM_Word;
  logic                oReady_AM_Word;
  logic [WT-1:0]       iData_AM_Word;

  logic                oValid_BM_Input;
  logic                iReady_BM_Input;
  logic [NI*WF-1:0]    oData_BM_Input;

  logic                oValid_BM_Teacher;
  logic                iReady_BM_Teacher;
  logic [NO*WT-1:0]    oData_BM_Teacher;

  modport master (
    input  iMode,
    input  iValid_AM_Word,
    output oReady_AM_Word,
    input  iData_AM_Word,
    output oValid_BM_Input,
    input  iReady_BM_Input,
    output oData_BM_Input,
    output oValid_BM_Teacher,
    input  iReady_BM_Teacher,
    output oData_BM_Teacher
  );

  modport slave (
    output iMode,
    output iValid_AM_Word,
    input  oReady_AM_Word,
    output iData_AM_Word,
    input  oValid_BM_Input,
    output iReady_BM_Input,
    input  oData_BM_Input,
    input  oValid_BM_Teacher,
    output iReady_BM_Teacher,
    input  oData_BM_Teacher
  );
endinterface

// File: rtl/network_feeder.sv
// Deserialises a narrow word stream into an input frame (plus a teacher frame in training mode).
// Optional frame counter port oFrameCount is enabled by defining NETWORK_FEEDER_FRAMECNT_EN.
module network_feeder #(
  parameter int NI  = 4,
  parameter int NH1 = 6,
  parameter int NO  = 7,
  parameter int WF  = 8
) (
  input  logic        iCLK,
  input  logic        iRST,
`ifdef NETWORK_FEEDER_FRAMECNT_EN
  output logic [15:0] oFrameCount,
`endif
  network_feeder_if.master bus
);
  localparam int WT   = $clog2(NH1) + 1 + WF;
  localparam int NMAX = (NI > NO) ? NI : NO;
  localparam int CW   = $clog2(NMAX) + 1;

  localparam logic [1:0] S_IN  = 2'd0;
  localparam logic [1:0] S_TCH = 2'd1;
  localparam logic [1:0] S_OUT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             vin_q, vin_d;
  logic             vtch_q, vtch_d;
  logic [NI*WF-1:0] in_buf_q, in_buf_d;
  logic [NO*WT-1:0] tch_buf_q, tch_buf_d;

  logic word_ready;
  logic word_acc;
  logic frame_mode;

  // Ready is gated by reset combinationally so upstream never sees it high while resetting.
  assign word_ready = !iRST && (state_q != S_OUT);
  assign word_acc   = bus.iValid_AM_Word && word_ready;
  // The first word of a frame decides its mode; later iMode changes are ignored.
  assign frame_mode = (cnt_q == '0) ? bus.iMode : mode_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    vin_d     = vin_q;
    vtch_d    = vtch_q;
    in_buf_d  = in_buf_q;
    tch_buf_d = tch_buf_q;

    case (state_q)
      S_IN: begin
        if (word_acc) begin
          for (int k = 0; k < NI; k++) begin
            if (cnt_q == CW'(k)) in_buf_d[k*WF +: WF] = bus.iData_AM_Word[WF-1:0];
          end
          mode_d = frame_mode;
          if (cnt_q == CW'(NI - 1)) begin
            cnt_d = '0;
            if (frame_mode) begin
              state_d = S_TCH;
            end else begin
              state_d = S_OUT;
              vin_d   = 1'b1;
              vtch_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_TCH: begin
        if (word_acc) begin
          for (int k = 0; k < NO; k++) begin
            if (cnt_q == CW'(k)) tch_buf_d[k*WT +: WT] = bus.iData_AM_Word;
          end
          if (cnt_q == CW'(NO - 1)) begin
            cnt_d   = '0;
            state_d = S_OUT;
            vin_d   = 1'b1;
            vtch_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_OUT: begin
        // Each bus retires on its own handshake; collection resumes once both are retired.
        if (vin_q && bus.iReady_BM_Input)    vin_d  = 1'b0;
        if (vtch_q && bus.iReady_BM_Teacher) vtch_d = 1'b0;
        if (!vin_d && !vtch_d)               state_d = S_IN;
      end

      default: begin
        state_d = S_IN;
        cnt_d   = '0;
        vin_d   = 1'b0;
        vtch_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (iRST) begin
      state_q   <= S_IN;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      vin_q     <= 1'b0;
      vtch_q    <= 1'b0;
      // NOTE: frame buffers are reset too, so outputs read as zero before the first frame.
      in_buf_q  <= '0;
      tch_buf_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      vin_q     <= vin_d;
      vtch_q    <= vtch_d;
      in_buf_q  <= in_buf_d;
      tch_buf_q <= tch_buf_d;
    end
  end

  assign bus.oReady_AM_Word    = word_ready;
  assign bus.oValid_BM_Input   = vin_q;
  assign bus.oData_BM_Input    = in_buf_q;
  assign bus.oValid_BM_Teacher = vtch_q;
  assign bus.oData_BM_Teacher  = tch_buf_q;

`ifdef NETWORK_FEEDER_FRAMECNT_EN
  logic        frame_done;
  logic [15:0] frame_cnt_q;

  // A frame counts when its last outstanding output handshake completes.
  assign frame_done = (state_q == S_OUT) && !vin_d && !vtch_d;

  always_ff @(posedge iCLK) begin
    if (iRST)            frame_cnt_q <= '0;
    else if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign oFrameCount = frame_cnt_q;
`endif
endmodule

// File: tb/tb_network_feeder.sv
// Randomised and directed bench for network_feeder against a frame-level queue model.
module tb_network_feeder;
  localparam int NI  = 4;
  localparam int NH1 = 6;
  localparam int NO  = 7;
  localparam int WF  = 8;
  localparam int WT  = $clog2(NH1) + 1 + WF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  network_feeder_if #(.NI(NI), .NH1(NH1), .NO(NO), .WF(WF)) bus ();

`ifdef NETWORK_FEEDER_FRAMECNT_EN
  logic [15:0] frame_count;
`endif

  network_feeder #(.NI(NI), .NH1(NH1), .NO(NO), .WF(WF)) dut (
    .iCLK        (clk),
    .iRST        (rst),
`ifdef NETWORK_FEEDER_FRAMECNT_EN
    .oFrameCount (frame_count),
`endif
    .bus         (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame-level model: a queue of words per frame, emitted whole once the frame length is reached.
  logic [WT-1:0]    m_q[$];
  bit               m_mode, m_present, m_vin, m_vtch;
  logic [NI*WF-1:0] m_in;
  logic [NO*WT-1:0] m_tch;
  int               m_fc;

  task automatic model_update();
    logic [WT-1:0] w;
    if (rst) begin
      m_q.delete();
      m_mode = 0; m_present = 0; m_vin = 0; m_vtch = 0;
      m_in = '0; m_tch = '0; m_fc = 0;
    end else if (!m_present) begin
      if (bus.iValid_AM_Word) begin
        m_q.push_back(bus.iData_AM_Word);
        if (m_q.size() == 1) m_mode = bus.iMode;
        if (m_q.size() == NI + (m_mode ? NO : 0)) begin
          for (int k = 0; k < NI; k++) begin
            w = m_q[k];
            m_in[k*WF +: WF] = w[WF-1:0];
          end
          if (m_mode) for (int k = 0; k < NO; k++) m_tch[k*WT +: WT] = m_q[NI+k];
          m_present = 1; m_vin = 1; m_vtch = m_mode;
          m_q.delete();
        end
      end
    end else begin
      if (m_vin && bus.iReady_BM_Input)    m_vin  = 0;
      if (m_vtch && bus.iReady_BM_Teacher) m_vtch = 0;
      if (!m_vin && !m_vtch) begin
        m_present = 0;
        m_fc = (m_fc + 1) % 65536;
      end
    end
  endtask

  task automatic compare_all();
    check("ready", bus.oReady_AM_Word, !rst && !m_present);
    check("valid_in", bus.oValid_BM_Input, m_vin);
    check("valid_tch", bus.oValid_BM_Teacher, m_vtch);
    if (m_vin)  check("data_in", bus.oData_BM_Input, m_in);
    if (m_vtch) check("data_tch", bus.oData_BM_Teacher, m_tch);
`ifdef NETWORK_FEEDER_FRAMECNT_EN
    check("frame_count", frame_count, m_fc);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic push(input logic [WT-1:0] w, input logic m);
    bus.iValid_AM_Word = 1'b1;
    bus.iData_AM_Word  = w;
    bus.iMode          = m;
    tick();
    bus.iValid_AM_Word = 1'b0;
  endtask

  task automatic drain();
    bus.iReady_BM_Input   = 1'b1;
    bus.iReady_BM_Teacher = 1'b1;
    tick();
    bus.iReady_BM_Input   = 1'b0;
    bus.iReady_BM_Teacher = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.iMode = 1'b0;
    bus.iValid_AM_Word = 1'b0;
    bus.iData_AM_Word = '0;
    bus.iReady_BM_Input = 1'b0;
    bus.iReady_BM_Teacher = 1'b0;
    tick();
    tick();
    check("rst_ready", bus.oReady_AM_Word, 1'b0);
    check("rst_vin", bus.oValid_BM_Input, 1'b0);
    check("rst_vtch", bus.oValid_BM_Teacher, 1'b0);
    check("rst_din", bus.oData_BM_Input, '0);
    check("rst_dtch", bus.oData_BM_Teacher, '0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", bus.oReady_AM_Word, 1'b1);

    // Inference frame
    for (int i = 1; i <= NI; i++) push(WT'(i), 1'b0);
    check("inf_vin", bus.oValid_BM_Input, 1'b1);
    check("inf_data", bus.oData_BM_Input, 32'h04030201);
    check("inf_vtch", bus.oValid_BM_Teacher, 1'b0);
    check("inf_ready", bus.oReady_AM_Word, 1'b0);
    drain();

    // Training frame, teacher released first, input three cycles later
    for (int i = 0; i < NI; i++) push(WT'(10 + i), 1'b1);
    for (int i = 1; i <= NO; i++) push(WT'(i), 1'b0);
    check("trn_vin", bus.oValid_BM_Input, 1'b1);
    check("trn_vtch", bus.oValid_BM_Teacher, 1'b1);
    check("trn_t6", bus.oData_BM_Teacher[6*WT +: WT], 12'h007);
    check("trn_t0", bus.oData_BM_Teacher[0 +: WT], 12'h001);
    bus.iValid_AM_Word = 1'b1;
    bus.iData_AM_Word  = 12'h055;
    tick();
    check("out_ready_low", bus.oReady_AM_Word, 1'b0);
    bus.iValid_AM_Word = 1'b0;
    bus.iReady_BM_Teacher = 1'b1;
    tick();
    bus.iReady_BM_Teacher = 1'b0;
    check("ord_vtch_drop", bus.oValid_BM_Teacher, 1'b0);
    check("ord_vin_hold", bus.oValid_BM_Input, 1'b1);
    tick();
    tick();
    bus.iReady_BM_Input = 1'b1;
    tick();
    bus.iReady_BM_Input = 1'b0;
    check("ord_vin_drop", bus.oValid_BM_Input, 1'b0);
    check("ord_ready_high", bus.oReady_AM_Word, 1'b1);

    // Training frame, simultaneous readies
    for (int i = 0; i < NI + NO; i++) push(WT'(100 + i), 1'b1);
    drain();
    check("sim_vin", bus.oValid_BM_Input, 1'b0);
    check("sim_vtch", bus.oValid_BM_Teacher, 1'b0);

    // Mode latched at first word only
    push(WT'(21), 1'b0);
    push(WT'(22), 1'b1);
    push(WT'(23), 1'b1);
    push(WT'(24), 1'b1);
    check("latch_vin", bus.oValid_BM_Input, 1'b1);
    check("latch_vtch", bus.oValid_BM_Teacher, 1'b0);
    drain();

    // Reset mid-frame discards partial frame
    push(WT'(1), 1'b0);
    push(WT'(2), 1'b0);
    rst = 1'b1;
    tick();
    check("midrst_vin", bus.oValid_BM_Input, 1'b0);
    rst = 1'b0;
    for (int i = 5; i <= 8; i++) push(WT'(i), 1'b0);
    check("midrst_data", bus.oData_BM_Input, 32'h08070605);
    drain();

    // Upper bits ignored in input phase
    for (int i = 0; i < NI; i++) push(WT'(12'hF0A + i), 1'b0);
    check("upper_data", bus.oData_BM_Input, 32'h0D0C0B0A);
    drain();

`ifdef NETWORK_FEEDER_FRAMECNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NI; i++) push(WT'(i), 1'b0);
      drain();
    end
    check("frame_count_3", frame_count, 16'd3);
`endif

    // Randomised traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.iValid_AM_Word    = ($urandom_range(0, 3) != 0);
      bus.iData_AM_Word     = WT'($urandom);
      bus.iMode             = 1'($urandom);
      bus.iReady_BM_Input   = 1'($urandom);
      bus.iReady_BM_Teacher = 1'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
